// File: rtl/cache_fill_fsm_if.sv
// Memory-side bus of the cache fill engine: pipelined word reads with in-order returns.
interface cache_fill_fsm_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  mem_enable;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_data_out;
  logic                  mem_data_valid;

  modport master (
    output mem_enable,
    output mem_wr,
    output mem_addr,
    input  mem_data_out,
    input  mem_data_valid
  );

  modport slave (
    input  mem_enable,
    input  mem_wr,
    input  mem_addr,
    output mem_data_out,
    output mem_data_valid
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache block fill engine: streams one block of word reads and writes returns into the cache.
// Optional build macro CRITICAL_WORD_FIRST_EN starts the fill at the missed word and wraps.
module cache_fill_fsm #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned BLOCK_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           miss_detected,
  input  logic [ADDR_WIDTH-1:0]          miss_address,
  output logic                           fsm_busy,
  cache_fill_fsm_if.master               mem,
  output logic                           write_data_array,
  output logic                           write_tag_array,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
  output logic [15:0]                    fill_data,
  output logic [ADDR_WIDTH-1:0]          fill_block_addr
);

  localparam int unsigned OffW = $clog2(BLOCK_WORDS);
  localparam int unsigned CntW = OffW + 1;
  localparam logic [ADDR_WIDTH-1:0] BlockMask = ~ADDR_WIDTH'(2 * BLOCK_WORDS - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(BLOCK_WORDS);
  localparam logic [CntW-1:0] CntLast = CntW'(BLOCK_WORDS - 1);

  typedef enum logic {StIdle, StFill} state_e;

  state_e                state_q;
  logic [OffW-1:0]       start_q;
  logic [CntW-1:0]       issue_cnt_q;
  logic [CntW-1:0]       recv_cnt_q;
  logic                  mem_enable_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;

  logic [ADDR_WIDTH-1:0] miss_base;
  logic [OffW-1:0]       miss_start;
  logic [OffW-1:0]       issue_off;
  logic [OffW-1:0]       recv_off;

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] base,
                                                      input logic [OffW-1:0]       off);
    return base | ADDR_WIDTH'({off, 1'b0});
  endfunction

  assign miss_base = miss_address & BlockMask;

`ifdef CRITICAL_WORD_FIRST_EN
  assign miss_start = miss_address[OffW:1];
`else
  assign miss_start = '0;
`endif

  // Offsets wrap naturally in OffW bits.
  assign issue_off = start_q + issue_cnt_q[OffW-1:0];
  assign recv_off  = start_q + recv_cnt_q[OffW-1:0];

  assign mem.mem_enable = mem_enable_q;
  assign mem.mem_addr   = mem_addr_q;
  assign mem.mem_wr     = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      start_q          <= '0;
      issue_cnt_q      <= '0;
      recv_cnt_q       <= '0;
      mem_enable_q     <= 1'b0;
      mem_addr_q       <= '0;
      fsm_busy         <= 1'b0;
      write_data_array <= 1'b0;
      write_tag_array  <= 1'b0;
      fill_word        <= '0;
      fill_data        <= '0;
      fill_block_addr  <= '0;
    end else begin
      write_data_array <= 1'b0;
      write_tag_array  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (miss_detected) begin
            state_q         <= StFill;
            fsm_busy        <= 1'b1;
            fill_block_addr <= miss_base;
            start_q         <= miss_start;
            recv_cnt_q      <= '0;
            // First read goes out on the accept edge, so one request is already counted.
            issue_cnt_q     <= CntW'(1);
            mem_enable_q    <= 1'b1;
            mem_addr_q      <= word_addr(miss_base, miss_start);
          end
        end
        StFill: begin
          if (issue_cnt_q < CntFull) begin
            mem_enable_q <= 1'b1;
            mem_addr_q   <= word_addr(fill_block_addr, issue_off);
            issue_cnt_q  <= issue_cnt_q + CntW'(1);
          end else begin
            mem_enable_q <= 1'b0;
            mem_addr_q   <= '0;
          end

          if (mem_data_valid_ok()) begin
            write_data_array <= 1'b1;
            fill_data        <= mem.mem_data_out;
            fill_word        <= recv_off;
            recv_cnt_q       <= recv_cnt_q + CntW'(1);
            if (recv_cnt_q == CntLast) begin
              write_tag_array <= 1'b1;
            end
          end

          // Leave once the tag write has been presented for its single cycle.
          if (write_tag_array) begin
            state_q         <= StIdle;
            fsm_busy        <= 1'b0;
            fill_word       <= '0;
            fill_data       <= '0;
            fill_block_addr <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  function automatic logic mem_data_valid_ok();
    return mem.mem_data_valid && (recv_cnt_q < CntFull);
  endfunction

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: vector table of fills plus reset, back-to-back and idle cases.
module tb_cache_fill_fsm;
  localparam int unsigned AW = 16;
  localparam int unsigned BW = 8;
`ifdef CRITICAL_WORD_FIRST_EN
  localparam bit Cwf = 1'b1;
`else
  localparam bit Cwf = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_detected;
  logic [AW-1:0] miss_address;
  logic          fsm_busy;
  logic          write_data_array;
  logic          write_tag_array;
  logic [2:0]    fill_word;
  logic [15:0]   fill_data;
  logic [AW-1:0] fill_block_addr;

  cache_fill_fsm_if #(.ADDR_WIDTH(AW)) mem ();

  cache_fill_fsm #(.ADDR_WIDTH(AW), .BLOCK_WORDS(BW)) dut (
    .clk              (clk),
    .rst              (rst),
    .miss_detected    (miss_detected),
    .miss_address     (miss_address),
    .fsm_busy         (fsm_busy),
    .mem              (mem),
    .write_data_array (write_data_array),
    .write_tag_array  (write_tag_array),
    .fill_word        (fill_word),
    .fill_data        (fill_data),
    .fill_block_addr  (fill_block_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] miss;
    int          lat;
    int          gap_rel;
    int          gap_len;
    logic [15:0] block;
    int          start_cwf;
    int          busy;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    int          ready;
  } resp_t;

  typedef struct {
    logic [2:0]  word;
    logic [15:0] data;
    logic        tag;
    logic [15:0] blk;
  } wr_t;

  int errors = 0;
  int checks = 0;

  // Memory model / monitor state (written only by the negedge process).
  resp_t       q[$];
  logic [15:0] issue_log[$];
  wr_t         wlog[$];
  int          rise_log[$];
  int          cyc = 0;
  int          n_resp = 0;
  int          n_busy = 0;
  int          n_tag = 0;
  int          gap_seen = -1;
  int          gap_used = 0;
  logic        busy_prev = 1'b0;
  logic        wr_seen = 1'b0;

  // Model controls (written only by the stimulus process).
  int lat = 1;
  int gap_at = -1;
  int gap_len = 0;
  int inj_until = -1;

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (mem.mem_enable) begin
      issue_log.push_back(mem.mem_addr);
      q.push_back('{data: mdata(mem.mem_addr), ready: cyc + lat});
    end
    if (mem.mem_wr) wr_seen = 1'b1;
    if (write_data_array)
      wlog.push_back('{word: fill_word, data: fill_data, tag: write_tag_array,
                       blk: fill_block_addr});
    if (write_tag_array) n_tag++;
    if (fsm_busy) n_busy++;
    if (fsm_busy && !busy_prev) rise_log.push_back(cyc);
    busy_prev = fsm_busy;
    if (gap_at != gap_seen) begin
      gap_seen = gap_at;
      gap_used = 0;
    end
    mem.mem_data_valid = 1'b0;
    mem.mem_data_out   = 16'h0000;
    if (q.size() > 0 && q[0].ready <= cyc) begin
      if (n_resp == gap_at && gap_used < gap_len) begin
        gap_used++;
      end else begin
        mem.mem_data_valid = 1'b1;
        mem.mem_data_out   = q[0].data;
        void'(q.pop_front());
        n_resp++;
      end
    end else if (cyc <= inj_until) begin
      mem.mem_data_valid = 1'b1;
      mem.mem_data_out   = 16'hDEAD;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, ".busy"}, 32'(fsm_busy), 0);
    check({name, ".mem_enable"}, 32'(mem.mem_enable), 0);
    check({name, ".mem_addr"}, 32'(mem.mem_addr), 0);
    check({name, ".mem_wr"}, 32'(mem.mem_wr), 0);
    check({name, ".wr_data"}, 32'(write_data_array), 0);
    check({name, ".wr_tag"}, 32'(write_tag_array), 0);
    check({name, ".fill_word"}, 32'(fill_word), 0);
    check({name, ".fill_data"}, 32'(fill_data), 0);
    check({name, ".fill_block"}, 32'(fill_block_addr), 0);
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (fsm_busy && t < 200) begin
      @(posedge clk);
      #1 t++;
    end
    check({name, ".timeout"}, 32'(t < 200), 1);
  endtask

  task automatic run_fill(input vec_t v);
    int ib, wb, bb, st, w, tags;
    st   = Cwf ? v.start_cwf : 0;
    ib   = issue_log.size();
    wb   = wlog.size();
    bb   = n_busy;
    tags = 0;
    lat     = v.lat;
    gap_len = v.gap_len;
    gap_at  = (v.gap_len > 0) ? n_resp + v.gap_rel : -1;
    miss_address  = v.miss;
    miss_detected = 1'b1;
    @(posedge clk);
    #1 miss_detected = 1'b0;
    check("busy_after_accept", 32'(fsm_busy), 1);
    wait_idle("fill");
    repeat (2) @(posedge clk);
    #1;
    check("busy_cycles", 32'(n_busy - bb), 32'(v.busy));
    check("issue_count", 32'(issue_log.size() - ib), BW);
    check("write_count", 32'(wlog.size() - wb), BW);
    if (issue_log.size() >= ib + BW && wlog.size() >= wb + BW) begin
      for (int k = 0; k < BW; k++) begin
        w = (st + k) % BW;
        check("mem_addr", 32'(issue_log[ib+k]), 32'(v.block) + 32'(2 * w));
        check("fill_word", 32'(wlog[wb+k].word), 32'(w));
        check("fill_data", 32'(wlog[wb+k].data), 32'(mdata(16'(v.block + 16'(2 * w)))));
        if (wlog[wb+k].tag) tags++;
      end
      check("tag_on_last", 32'(wlog[wb+BW-1].tag), 1);
      check("tag_block", 32'(wlog[wb+BW-1].blk), 32'(v.block));
    end
    check("tag_count", 32'(tags), 1);
    check_idle("after_fill");
  endtask

  vec_t vecs[5];

  initial begin
    int t, rb, wb, wb2, nt, bb, rl;
    vecs[0] = '{miss: 16'h1234, lat: 4, gap_rel: -1, gap_len: 0, block: 16'h1230,
                start_cwf: 2, busy: 13};
    vecs[1] = '{miss: 16'hABCE, lat: 1, gap_rel: -1, gap_len: 0, block: 16'hABC0,
                start_cwf: 7, busy: 10};
    vecs[2] = '{miss: 16'h1234, lat: 4, gap_rel: 4, gap_len: 2, block: 16'h1230,
                start_cwf: 2, busy: 15};
    vecs[3] = '{miss: 16'hFFFF, lat: 2, gap_rel: -1, gap_len: 0, block: 16'hFFF0,
                start_cwf: 7, busy: 11};
    vecs[4] = '{miss: 16'h0000, lat: 3, gap_rel: -1, gap_len: 0, block: 16'h0000,
                start_cwf: 0, busy: 12};

    rst = 1'b1;
    miss_detected = 1'b0;
    miss_address  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_idle("reset");

    for (int i = 0; i < 5; i++) run_fill(vecs[i]);

    // Reset in the middle of a fill; late returns must not write.
    rb = n_resp;
    wb = wlog.size();
    lat = 4;
    gap_at = -1;
    miss_address  = 16'h1234;
    miss_detected = 1'b1;
    @(posedge clk);
    #1 miss_detected = 1'b0;
    t = 0;
    while (n_resp - rb < 3 && t < 100) begin
      @(posedge clk);
      #1 t++;
    end
    check("third_resp_timeout", 32'(t < 100), 1);
    check("writes_before_reset", 32'(wlog.size() - wb), 2);
    rst = 1'b1;
    #1 check_idle("rst_mid_fill");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wb2 = wlog.size();
    nt  = n_tag;
    t = 0;
    while (q.size() > 0 && t < 50) begin
      @(posedge clk);
      #1 t++;
    end
    check("drain_timeout", 32'(t < 50), 1);
    repeat (2) @(posedge clk);
    #1;
    check("late_valid_writes", 32'(wlog.size() - wb2), 0);
    check("late_valid_tags", 32'(n_tag - nt), 0);
    check_idle("after_late_valids");
    run_fill(vecs[1]);

    // Miss held through a fill and one cycle past busy falling: exactly two fills.
    rl = rise_log.size();
    wb = wlog.size();
    bb = n_busy;
    nt = n_tag;
    lat = 2;
    gap_at = -1;
    miss_address  = 16'h1234;
    miss_detected = 1'b1;
    @(posedge clk);
    #1 check("b2b_first_busy", 32'(fsm_busy), 1);
    wait_idle("b2b_first");
    @(posedge clk);
    #1 miss_detected = 1'b0;
    check("b2b_second_busy", 32'(fsm_busy), 1);
    wait_idle("b2b_second");
    repeat (3) @(posedge clk);
    #1;
    check("b2b_fills", 32'(rise_log.size() - rl), 2);
    if (rise_log.size() >= rl + 2)
      check("b2b_restart_gap", 32'(rise_log[rl+1] - rise_log[rl]), 12);
    check("b2b_writes", 32'(wlog.size() - wb), 16);
    check("b2b_tags", 32'(n_tag - nt), 2);
    check("b2b_busy_cycles", 32'(n_busy - bb), 22);
    check("mem_wr_never", 32'(wr_seen), 0);

    // Stray returns while idle.
    wb = wlog.size();
    nt = n_tag;
    inj_until = cyc + 4;
    repeat (8) @(posedge clk);
    #1;
    check("idle_valid_writes", 32'(wlog.size() - wb), 0);
    check("idle_valid_tags", 32'(n_tag - nt), 0);
    check_idle("idle_valid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
